// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_unit
//  Purpose  : RV32I decode->execute hazard unit with forwarding select,
//             load-use stall, redirect flush and saturating perf counters.
//  Revision : 1.0
// ============================================================================
module pipe_hazard_unit #(
    parameter int  NREG     = 32,
    parameter int  DEPTH    = 3,
    parameter int  LOAD_LAT = 1,
    parameter int  CNT_W    = 32,
    localparam int RAW      = $clog2(NREG),
    localparam int SW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [RAW-1:0]   issue_rs1,
    input  logic [RAW-1:0]   issue_rs2,
    input  logic             issue_rs1_used,
    input  logic             issue_rs2_used,
    input  logic [RAW-1:0]   issue_rd,
    input  logic             issue_rd_we,
    input  logic             issue_is_load,
    input  logic             redirect,
    output logic             issue_accept,
    output logic             stall,
    output logic             flush,
    output logic [SW-1:0]    fwd_sel_a,
    output logic [SW-1:0]    fwd_sel_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int            WW          = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
    localparam logic [WW-1:0] c_LOAD_WAIT = WW'(LOAD_LAT);

    logic           r_valid [DEPTH];
    logic           r_rd_we [DEPTH];
    logic [RAW-1:0] r_rd    [DEPTH];
    logic [WW-1:0]  r_wait  [DEPTH];

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [SW-1:0] w_sel_a;
    logic [SW-1:0] w_sel_b;
    logic          w_haz_a;
    logic          w_haz_b;
    logic          w_hazard;

    // Oldest-to-youngest scan so the youngest matching slot wins.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_haz_a = 1'b0;
        w_haz_b = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (issue_rs1_used && (issue_rs1 != '0) && r_valid[i] && r_rd_we[i]
                && (r_rd[i] == issue_rs1)) begin
                w_sel_a = SW'(i + 1);
                w_haz_a = (r_wait[i] != '0);
            end
            if (issue_rs2_used && (issue_rs2 != '0) && r_valid[i] && r_rd_we[i]
                && (r_rd[i] == issue_rs2)) begin
                w_sel_b = SW'(i + 1);
                w_haz_b = (r_wait[i] != '0);
            end
        end
    end

    assign w_hazard     = w_haz_a | w_haz_b;
    assign stall        = rst & issue_valid & w_hazard & ~redirect;
    assign flush        = rst & redirect;
    assign issue_accept = rst & issue_valid & ~w_hazard & ~redirect;
    assign fwd_sel_a    = rst ? w_sel_a : '0;
    assign fwd_sel_b    = rst ? w_sel_b : '0;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_rd_we[i] <= 1'b0;
                r_rd[i]    <= '0;
                r_wait[i]  <= '0;
            end
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_valid[0] <= issue_accept;
            r_rd_we[0] <= issue_rd_we;
            r_rd[0]    <= issue_rd;
            r_wait[0]  <= issue_is_load ? c_LOAD_WAIT : '0;
            // Wait counts down as the load moves toward its result stage.
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_rd_we[i] <= r_rd_we[i-1];
                r_rd[i]    <= r_rd[i-1];
                r_wait[i]  <= (r_wait[i-1] != '0) ? (r_wait[i-1] - WW'(1)) : '0;
            end
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_unit
//  Purpose  : Directed table-driven bench for pipe_hazard_unit (three configs).
//  Revision : 1.0
// ============================================================================
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_valid;
    logic [4:0] issue_rs1, issue_rs2, issue_rd;
    logic       issue_rs1_used, issue_rs2_used, issue_rd_we, issue_is_load, redirect;

    logic        acc0, st0, fl0, acc1, st1, fl1, acc2, st2, fl2;
    logic [1:0]  sa0, sb0, sa1, sb1, sa2, sb2;
    logic [31:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit u_dut0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load),
        .redirect(redirect), .issue_accept(acc0), .stall(st0), .flush(fl0),
        .fwd_sel_a(sa0), .fwd_sel_b(sb0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    pipe_hazard_unit #(.LOAD_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load),
        .redirect(redirect), .issue_accept(acc1), .stall(st1), .flush(fl1),
        .fwd_sel_a(sa1), .fwd_sel_b(sb1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    pipe_hazard_unit #(.CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load),
        .redirect(redirect), .issue_accept(acc2), .stall(st2), .flush(fl2),
        .fwd_sel_a(sa2), .fwd_sel_b(sb2), .stall_cnt(sc2), .flush_cnt(fc2)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       redir;
        logic       acc;
        logic       st;
        logic       fl;
        logic [1:0] sa;
        logic [1:0] sb;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        issue_valid    = t.v;
        issue_rs1      = t.rs1;
        issue_rs1_used = t.u1;
        issue_rs2      = t.rs2;
        issue_rs2_used = t.u2;
        issue_rd       = t.rd;
        issue_rd_we    = t.we;
        issue_is_load  = t.ld;
        redirect       = t.redir;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        issue_rs1_used = 1'b0; issue_rs2_used = 1'b0; issue_rd_we = 1'b0;
        issue_is_load = 1'b0; redirect = 1'b0;
    endtask

    task automatic do_reset(input bit check);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst            = 1'b0;
            issue_valid    = 1'($urandom);
            issue_rs1      = 5'($urandom);
            issue_rs2      = 5'($urandom);
            issue_rd       = 5'($urandom);
            issue_rs1_used = 1'($urandom);
            issue_rs2_used = 1'($urandom);
            issue_rd_we    = 1'($urandom);
            issue_is_load  = 1'($urandom);
            redirect       = 1'($urandom);
            #2;
            if (check) begin
                chk("rst.stall", {31'd0, st0}, 32'd0);
                chk("rst.flush", {31'd0, fl0}, 32'd0);
                chk("rst.accept", {31'd0, acc0}, 32'd0);
                chk("rst.sel_a", {30'd0, sa0}, 32'd0);
                chk("rst.sel_b", {30'd0, sb0}, 32'd0);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        idle();
        #2;
        if (check) begin
            chk("rst.stall_cnt", sc0, 32'd0);
            chk("rst.flush_cnt", fc0, 32'd0);
            chk("rst.stall_cnt4", {28'd0, sc2}, 32'd0);
        end
    endtask

    initial begin
        //          v  rs1 u1 rs2 u2 rd we ld rd  acc st fl sa sb
        tbl[0]  = '{1, 1,  1, 2,  1, 5, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[1]  = '{1, 5,  1, 6,  1, 8, 1, 0, 0,  1, 0, 0, 1, 0};
        tbl[2]  = '{1, 9,  1, 10, 1, 11,1, 0, 0,  1, 0, 0, 0, 0};
        tbl[3]  = '{1, 5,  1, 8,  1, 12,1, 0, 0,  1, 0, 0, 3, 2};
        tbl[4]  = '{1, 5,  1, 11, 1, 13,1, 0, 0,  1, 0, 0, 0, 2};
        tbl[5]  = '{1, 0,  1, 0,  1, 3, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[6]  = '{1, 3,  1, 1,  1, 3, 1, 0, 0,  1, 0, 0, 1, 0};
        tbl[7]  = '{1, 3,  1, 3,  1, 14,1, 0, 0,  1, 0, 0, 1, 1};
        tbl[8]  = '{1, 0,  1, 0,  0, 0, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[9]  = '{1, 0,  1, 14, 0, 15,1, 0, 0,  1, 0, 0, 0, 0};
        tbl[10] = '{1, 15, 1, 0,  0, 7, 1, 1, 0,  1, 0, 0, 1, 0};
        tbl[11] = '{1, 1,  1, 7,  1, 16,1, 0, 0,  0, 1, 0, 0, 1};
        tbl[12] = '{1, 1,  1, 7,  1, 16,1, 0, 0,  1, 0, 0, 0, 2};
        tbl[13] = '{1, 0,  1, 0,  0, 9, 1, 1, 0,  1, 0, 0, 0, 0};
        tbl[14] = '{1, 9,  1, 16, 1, 17,1, 0, 1,  0, 0, 1, 1, 2};
        tbl[15] = '{1, 9,  1, 17, 1, 18,1, 0, 0,  1, 0, 0, 2, 0};
        tbl[16] = '{0, 18, 1, 0,  0, 0, 0, 0, 1,  0, 0, 1, 1, 0};
        tbl[17] = '{0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0};

        idle();
        do_reset(1'b1);

        // Main sequence: forwarding distance, youngest-wins, x0, load-use, redirect.
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            drive(tbl[r]);
            #2;
            chk($sformatf("row%0d.accept", r), {31'd0, acc0}, {31'd0, tbl[r].acc});
            chk($sformatf("row%0d.stall", r),  {31'd0, st0},  {31'd0, tbl[r].st});
            chk($sformatf("row%0d.flush", r),  {31'd0, fl0},  {31'd0, tbl[r].fl});
            chk($sformatf("row%0d.sel_a", r),  {30'd0, sa0},  {30'd0, tbl[r].sa});
            chk($sformatf("row%0d.sel_b", r),  {30'd0, sb0},  {30'd0, tbl[r].sb});
        end
        @(negedge clk);
        idle();
        #2;
        chk("table.stall_cnt", sc0, 32'd1);
        chk("table.flush_cnt", fc0, 32'd2);

        // Mid-run reset must discard an in-flight load tag.
        @(negedge clk);
        drive('{1, 0, 0, 0, 0, 20, 1, 1, 0, 1, 0, 0, 0, 0});
        do_reset(1'b1);
        @(negedge clk);
        drive('{1, 20, 1, 0, 0, 21, 1, 0, 0, 1, 0, 0, 0, 0});
        #2;
        chk("postrst.sel_a", {30'd0, sa0}, 32'd0);
        chk("postrst.stall", {31'd0, st0}, 32'd0);
        chk("postrst.accept", {31'd0, acc0}, 32'd1);

        // LOAD_LAT=2 load-use: two stall cycles, forwarding slot advances.
        do_reset(1'b0);
        @(negedge clk);
        drive('{1, 0, 1, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 0});
        #2;
        chk("ll2.ld_accept", {31'd0, acc1}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive('{1, 1, 1, 7, 1, 16, 1, 0, 0, 0, 0, 0, 0, 0});
            #2;
            chk($sformatf("ll2.c%0d.stall", c), {31'd0, st1}, (c < 2) ? 32'd1 : 32'd0);
            chk($sformatf("ll2.c%0d.accept", c), {31'd0, acc1}, (c < 2) ? 32'd0 : 32'd1);
            chk($sformatf("ll2.c%0d.sel_b", c), {30'd0, sb1}, 32'(c + 1));
        end
        @(negedge clk);
        idle();
        #2;
        chk("ll2.stall_cnt", sc1, 32'd2);

        // Back-to-back dependent loads: one stall every other cycle, 20 in total.
        do_reset(1'b0);
        for (int c = 0; c < 41; c++) begin
            @(negedge clk);
            drive('{1, 7, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0});
        end
        @(negedge clk);
        idle();
        #2;
        chk("sat.stall_cnt4", {28'd0, sc2}, 32'd15);
        chk("sat.stall_cnt32", sc0, 32'd20);
        chk("sat.flush_cnt4", {28'd0, fc2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the in-order RV32I pipeline; adds operand forwarding, load-use stalls and branch-redirect flushing.
- Sits beside the decode→execute boundary.
- Tracks every in-flight destination register in a DEPTH-entry tag pipeline.
- Per issued instruction, decides one of: issue, stall, or forward from a specific downstream stage.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- NREG, 32, architectural register count; RAW = $clog2(NREG) is the register address width.
- DEPTH, 3, in-flight stages after decode (E, M, W); entries beyond DEPTH are committed to the register file.
- LOAD_LAT, 1, extra cycles before a load result can be forwarded.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- issue_valid  in  1  decode holds a valid instruction
- issue_rs1  in  RAW  source register 1
- issue_rs2  in  RAW  source register 2
- issue_rs1_used  in  1  rs1 is read
- issue_rs2_used  in  1  rs2 is read
- issue_rd  in  RAW  destination register
- issue_rd_we  in  1  instruction writes rd
- issue_is_load  in  1  instruction is a load
- redirect  in  1  taken branch/jump resolved in E this cycle
- issue_accept  out  1  instruction enters E at the next edge
- stall  out  1  hold fetch/decode
- flush  out  1  squash the decode and fetch instructions
- fwd_sel_a  out  $clog2(DEPTH+1)  rs1 source: 0 = regfile, k = stage slot k-1
- fwd_sel_b  out  $clog2(DEPTH+1)  rs2 source, same encoding
- stall_cnt  out  CNT_W  stall cycles
- flush_cnt  out  CNT_W  flush cycles

Behaviour:
- Reset: synchronous on a clk edge while rst=0.
  - All slots invalid; counters 0.
  - stall=0, flush=0, issue_accept=0, fwd_sel_a=fwd_sel_b=0.
  - rst=0 mid-operation discards every in-flight tag at that edge.
- Slot contents: slot[i], i=0..DEPTH-1, holds {valid, rd, rd_we, wait}. slot[0] is the instruction currently in E.
- Slot shift, every edge: slot[i] <= slot[i-1] for i≥1. Each shifted wait is decremented, saturating at 0.
- slot[0] load:
  - If issue_accept: slot[0] <= {1, issue_rd, issue_rd_we, issue_is_load ? LOAD_LAT : 0}.
  - Otherwise slot[0] <= bubble (valid=0).
- Match rule, per used source rs: slot[i] matches when valid && rd_we && rd==rs && rs!=0.
  - x0 never matches.
  - An unused source never matches.
- Forwarding:
  - Select the youngest (lowest i) matching slot.
  - If its wait==0: fwd_sel = i+1.
  - If its wait>0: hazard; fwd_sel still reports i+1.
  - No match: fwd_sel = 0.
  - Older matches are ignored.
- All outputs except the counters are combinational from the slots and current inputs.
  - stall = issue_valid && hazard(rs1 or rs2) && !redirect.
  - flush = redirect.
  - issue_accept = issue_valid && !stall && !redirect.
- Redirect priority:
  - redirect overrides stall: flush=1, stall=0, and the decode instruction is dropped.
  - Older slots, including the branch in slot[0], continue shifting unchanged.
- Counters, at the clk edge:
  - stall_cnt increments on cycles with stall=1.
  - flush_cnt increments on cycles with flush=1.
  - A cycle with both stall and redirect active counts as a flush only.
  - Both counters saturate at all-ones; no wrap.
- Register-file assumption: once an entry leaves slot[DEPTH-1], the register file must return its value in the same cycle (write-first or internal bypass); the unit no longer tracks it.
- Latency: a load followed immediately by a dependent instruction costs exactly LOAD_LAT stall cycles. An ALU result followed immediately by a dependent instruction costs 0 stall cycles.

Test Plan:
- Reset with random inputs held, rst=0 for 2 cycles → stall=0, flush=0, fwd_sel_a=fwd_sel_b=0, counters=0; the next issue is not checked against any pre-reset tag.
- Forwarding distance, defaults:
  - Issue ADD x5; next cycle issue SUB reading rs1=x5 → fwd_sel_a=1, stall=0.
  - Same pair with one independent instruction between → fwd_sel_a=2.
  - With two instructions between → fwd_sel_a=3.
  - With three instructions between → fwd_sel_a=0.
- Load-use: issue LW x7, then ADD with rs2=x7.
  - Cycle 1: stall=1, issue_accept=0, fwd_sel_b=1.
  - Cycle 2: stall=0, fwd_sel_b=2.
  - stall_cnt=1 afterwards.
  - Rerun with LOAD_LAT=2 → 2 stall cycles.
- Youngest-wins: ADD x3, then OR x3, then AND reading x3 → fwd_sel_a=1 (the OR), not 2.
- x0 and unused sources:
  - ADDI x0, then a dependent read of x0 → fwd_sel=0, stall=0.
  - rs2_used=0 with a matching rs2 → fwd_sel_b=0.
- Redirect during a load-use stall → flush=1, stall=0, issue_accept=0, slot[0] becomes a bubble, flush_cnt+1, stall_cnt unchanged.
- Counter saturation, CNT_W=4: force 20 stall cycles → stall_cnt holds 15.
